// File: rtl/ddc_capture_buf_pkg.sv
// ddc_capture_buf_pkg
//   Shared constants for the DDC snapshot buffer: register offsets within the
//   5-word SPI window, CTRL and STATUS bit positions, and FSM state encodings.
package ddc_capture_buf_pkg;

   // Register offsets relative to ADDR_BASE
   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_DATA   = 3'd2;
   localparam logic [2:0] REG_LENGTH = 3'd3;
   localparam logic [2:0] REG_TRIG   = 3'd4;
   localparam logic [6:0] REG_COUNT  = 7'd5;

   // CTRL bit positions
   localparam int unsigned CTRL_ARM       = 0;
   localparam int unsigned CTRL_ABORT     = 1;
   localparam int unsigned CTRL_TRIG_EN   = 2;
   localparam int unsigned CTRL_DECIM_LSB = 8;

   // STATUS bit positions
   localparam int unsigned STAT_ARMED     = 0;
   localparam int unsigned STAT_CAPTURING = 1;
   localparam int unsigned STAT_DONE      = 2;
   localparam int unsigned STAT_OVERRUN   = 3;
   localparam int unsigned STAT_WORDS_LSB = 16;

   // FSM state encodings
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_ARMED   = 2'd1;
   localparam state_t ST_CAPTURE = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/ddc_capture_buf_ram.sv
// capbuf_ram
//   Simple dual-port 32-bit RAM, 2**AW words, one write port and one read
//   port with a registered read (one clock latency). No reset on the array or
//   the read register so it maps onto block RAM.
// Ports
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdat   in   write data
//   raddr  in   read address
//   rdat   out  registered read data, mem[raddr] from the previous clock
module capbuf_ram #(
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdat,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdat
);

   logic [31:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdat;
      rdat <= mem[raddr];
   end

endmodule

// File: rtl/ddc_capture_buf.sv
// ddc_capture_buf
//   SPI-readable snapshot buffer for DDC output. Each accepted sample set
//   (NCH channels of dsz bits) is serialised into NCH consecutive RAM words,
//   sign-extended to 32 bits, channel 0 first. Capture is armed through CTRL,
//   optionally waits for |ch0| > TRIG, optionally decimates, and stops after
//   LENGTH sets. The host drains the RAM through the DATA register.
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high
//   we        in   register write strobe (1 clk)
//   re        in   register read strobe (1 clk); advances pointer on DATA
//   addr      in   7-bit register address
//   wdat      in   write data
//   rdat      out  read data, combinational on addr, 0 when hit=0
//   hit       out  addr within ADDR_BASE..ADDR_BASE+4
//   in_valid  in   sample set strobe
//   in_dat    in   packed signed samples, channel 0 in LSBs
//   busy      out  FSM in ARMED or CAPTURE
module ddc_capture_buf #(
   parameter int         dsz       = 16,
   parameter int         NCH       = 2,
   parameter int         AW        = 9,
   parameter logic [6:0] ADDR_BASE = 7'h20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic               re,
   input  logic [6:0]         addr,
   input  logic [31:0]        wdat,
   output logic [31:0]        rdat,
   output logic               hit,
   input  logic               in_valid,
   input  logic [NCH*dsz-1:0] in_dat,
   output logic               busy
);

   import ddc_capture_buf_pkg::*;

   // LENGTH is kept one bit wider than AW so that NCH=1 can hold 2**AW sets
   localparam int LW     = AW + 1;
   localparam int MAXLEN = (2**AW) / NCH;

   // ---------------- register decode ----------------
   logic [6:0] off;
   logic       wr_ctrl, wr_len, wr_trig, rd_data;
   logic       ctrl_arm, ctrl_abort;

   assign off        = addr - ADDR_BASE;
   assign hit        = (off < REG_COUNT);
   assign wr_ctrl    = we && hit && (off[2:0] == REG_CTRL);
   assign wr_len     = we && hit && (off[2:0] == REG_LENGTH);
   assign wr_trig    = we && hit && (off[2:0] == REG_TRIG);
   assign rd_data    = re && hit && (off[2:0] == REG_DATA);
   // abort wins when both bits are set in the same write
   assign ctrl_abort = wr_ctrl && wdat[CTRL_ABORT];
   assign ctrl_arm   = wr_ctrl && wdat[CTRL_ARM] && !wdat[CTRL_ABORT];

   // ---------------- state ----------------
   state_t             state;
   logic [LW-1:0]      length;
   logic [dsz-1:0]     trig;
   logic               trig_en;
   logic [7:0]         decim;
   logic [7:0]         dcnt;
   logic               overrun;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [15:0]        words;
   logic [LW-1:0]      sets;
   logic               ser_busy;
   logic [3:0]         ser_left;
   logic [NCH*dsz-1:0] shadow;
   logic [31:0]        ram_q;
   logic [31:0]        data_q;

   // ---------------- LENGTH write clamp ----------------
   logic [LW-1:0] len_new;

   always_comb begin
      len_new = wdat[LW-1:0];
      if (wdat == 32'd0)
         len_new = LW'(1);
      else if (wdat > 32'(MAXLEN))
         len_new = LW'(MAXLEN);
   end

   // ---------------- trigger magnitude ----------------
   logic [dsz-1:0] ch0, ch0_neg, mag;
   logic           trig_hit;

   assign ch0     = in_dat[dsz-1:0];
   assign ch0_neg = ~ch0 + 1'b1;

   // negating the most negative value wraps back to itself (MSB still set);
   // that case saturates to the largest positive magnitude
   always_comb begin
      mag = ch0;
      if (ch0[dsz-1]) begin
         if (ch0_neg[dsz-1])
            mag = {1'b0, {(dsz-1){1'b1}}};
         else
            mag = ch0_neg;
      end
   end

   assign trig_hit = !trig_en || (mag > trig);

   // ---------------- capture qualification ----------------
   logic cap_open, consider, take, store;

   assign cap_open = (state == ST_ARMED) ||
                     ((state == ST_CAPTURE) && (sets < length));
   // sets arriving while the serialiser is busy are dropped and do not
   // advance the decimator
   assign consider = in_valid && !ser_busy && cap_open;
   assign take     = consider && (dcnt == 8'd0);
   assign store    = take && ((state == ST_CAPTURE) || trig_hit);

   // ---------------- sequential ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         length   <= LW'(1);
         trig     <= '0;
         trig_en  <= 1'b0;
         decim    <= '0;
         dcnt     <= '0;
         overrun  <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         words    <= '0;
         sets     <= '0;
         ser_busy <= 1'b0;
         ser_left <= '0;
         shadow   <= '0;
         data_q   <= '0;
      end else begin
         if (wr_ctrl) begin
            trig_en <= wdat[CTRL_TRIG_EN];
            decim   <= wdat[CTRL_DECIM_LSB +: 8];
         end
         if (wr_len)
            length <= len_new;
         if (wr_trig)
            trig <= wdat[dsz-1:0];

         if (rd_data)
            rd_ptr <= rd_ptr + 1'b1;

         // second read stage: DATA always shows RAM[rd_ptr] two clocks on
         data_q <= ram_q;

         if (ctrl_abort) begin
            state    <= ST_IDLE;
            ser_busy <= 1'b0;
         end else if (ctrl_arm) begin
            state    <= ST_ARMED;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            words    <= '0;
            sets     <= '0;
            overrun  <= 1'b0;
            dcnt     <= '0;
            ser_busy <= 1'b0;
         end else begin
            if (ser_busy) begin
               wr_ptr   <= wr_ptr + 1'b1;
               words    <= words + 1'b1;
               shadow   <= shadow >> dsz;
               ser_left <= ser_left - 1'b1;
               if (ser_left == 4'd0) begin
                  ser_busy <= 1'b0;
                  // DONE only once the final set is fully in RAM
                  if (sets >= length)
                     state <= ST_DONE;
               end
               if (in_valid && (state == ST_CAPTURE))
                  overrun <= 1'b1;
            end

            if (consider) begin
               if (dcnt == 8'd0)
                  dcnt <= decim;
               else
                  dcnt <= dcnt - 1'b1;
            end

            if (store) begin
               ser_busy <= 1'b1;
               ser_left <= 4'(NCH - 1);
               shadow   <= in_dat;
               sets     <= sets + 1'b1;
               state    <= ST_CAPTURE;
            end
         end
      end
   end

   // ---------------- RAM ----------------
   logic        ram_we;
   logic [31:0] ram_wdat;

   assign ram_we   = ser_busy && !ctrl_abort && !ctrl_arm;
   assign ram_wdat = 32'($signed(shadow[dsz-1:0]));

   capbuf_ram #(
      .AW(AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdat  (ram_wdat),
      .raddr (rd_ptr),
      .rdat  (ram_q)
   );

   // ---------------- readback ----------------
   logic [31:0] status;

   always_comb begin
      status                          = '0;
      status[STAT_ARMED]              = (state == ST_ARMED);
      status[STAT_CAPTURING]          = (state == ST_CAPTURE);
      status[STAT_DONE]               = (state == ST_DONE);
      status[STAT_OVERRUN]            = overrun;
      status[STAT_WORDS_LSB +: 16]    = words;
   end

   always_comb begin
      rdat = '0;
      if (hit) begin
         case (off[2:0])
            REG_CTRL:   rdat = {16'd0, decim, 5'd0, trig_en, 2'd0};
            REG_STATUS: rdat = status;
            REG_DATA:   rdat = data_q;
            REG_LENGTH: rdat = 32'(length);
            REG_TRIG:   rdat = 32'(trig);
            default:    rdat = '0;
         endcase
      end
   end

   assign busy = (state == ST_ARMED) || (state == ST_CAPTURE);

endmodule

// File: tb/tb_ddc_capture_buf.sv
// tb_ddc_capture_buf
//   Directed bench for ddc_capture_buf with default parameters (dsz=16,
//   NCH=2, AW=9, ADDR_BASE=7'h20). Register reads push their expected value
//   into a queue; a monitor pops and compares on every read strobe.
module tb_ddc_capture_buf;

   localparam int         DSZ  = 16;
   localparam int         NCHN = 2;
   localparam int         AWD  = 9;
   localparam logic [6:0] BASE = 7'h20;

   localparam logic [6:0] A_CTRL   = BASE + 7'd0;
   localparam logic [6:0] A_STATUS = BASE + 7'd1;
   localparam logic [6:0] A_DATA   = BASE + 7'd2;
   localparam logic [6:0] A_LENGTH = BASE + 7'd3;
   localparam logic [6:0] A_TRIG   = BASE + 7'd4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  we, re;
   logic [6:0]            addr;
   logic [31:0]           wdat;
   logic [31:0]           rdat;
   logic                  hit;
   logic                  in_valid;
   logic [NCHN*DSZ-1:0]   in_dat;
   logic                  busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
      logic        exp_hit;
      logic        chk_busy;
      logic        exp_busy;
   } item_t;

   item_t exp_q[$];

   ddc_capture_buf #(
      .dsz       (DSZ),
      .NCH       (NCHN),
      .AW        (AWD),
      .ADDR_BASE (BASE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .we       (we),
      .re       (re),
      .addr     (addr),
      .wdat     (wdat),
      .rdat     (rdat),
      .hit      (hit),
      .in_valid (in_valid),
      .in_dat   (in_dat),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // ---------------- monitor ----------------
   initial begin
      item_t it;
      forever begin
         @(negedge clk);
         if (re) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_read addr=%h rdat=%h expected no read", addr, rdat);
            end else begin
               it = exp_q.pop_front();
               total++;
               if (rdat !== it.exp) begin
                  bad++;
                  $display("FAIL %s rdat got=%h exp=%h", it.name, rdat, it.exp);
               end
               total++;
               if (hit !== it.exp_hit) begin
                  bad++;
                  $display("FAIL %s hit got=%b exp=%b", it.name, hit, it.exp_hit);
               end
               if (it.chk_busy) begin
                  total++;
                  if (busy !== it.exp_busy) begin
                     bad++;
                     $display("FAIL %s busy got=%b exp=%b", it.name, busy, it.exp_busy);
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      we = 1'b1; addr = a; wdat = d;
      @(posedge clk); #1;
      we = 1'b0; addr = 7'h00; wdat = '0;
      repeat (3) @(posedge clk);
   endtask

   task automatic push_read(input logic [6:0] a, input string nm, input logic [31:0] e,
                            input logic eh, input logic cb, input logic eb);
      item_t it;
      it.name = nm; it.exp = e; it.exp_hit = eh; it.chk_busy = cb; it.exp_busy = eb;
      exp_q.push_back(it);
      @(posedge clk); #1;
      re = 1'b1; addr = a;
      @(posedge clk); #1;
      re = 1'b0; addr = 7'h00;
      repeat (3) @(posedge clk);
   endtask

   task automatic rd(input logic [6:0] a, input string nm, input logic [31:0] e);
      push_read(a, nm, e, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic rd_busy(input logic [6:0] a, input string nm, input logic [31:0] e, input logic b);
      push_read(a, nm, e, 1'b1, 1'b1, b);
   endtask

   task automatic rd_miss(input logic [6:0] a, input string nm);
      push_read(a, nm, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_valid(input logic [31:0] d);
      @(posedge clk); #1;
      in_valid = 1'b1; in_dat = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (14) @(posedge clk);
   endtask

   task automatic send_pair(input logic [31:0] d0, input logic [31:0] d1);
      @(posedge clk); #1;
      in_valid = 1'b1; in_dat = d0;
      @(posedge clk); #1;
      in_dat = d1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (14) @(posedge clk);
   endtask

   // ---------------- directed vectors ----------------
   logic [31:0] t1_in   [4] = '{32'hFFFF_0001, 32'hFFFE_0002, 32'hFFFD_0003, 32'hFFFC_0004};
   logic [31:0] t1_data [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE,
                                32'h0000_0003, 32'hFFFF_FFFD, 32'h0000_0004, 32'hFFFF_FFFC};
   logic [31:0] t2_in   [4] = '{32'h0000_0032, 32'h0000_FFB0, 32'h0000_FF6A, 32'h0000_0014};
   logic [31:0] t2_data [4] = '{32'hFFFF_FF6A, 32'h0000_0000, 32'h0000_0014, 32'h0000_0000};
   logic [31:0] t3_data [6] = '{32'd0, 32'd100, 32'd3, 32'd103, 32'd6, 32'd106};

   initial begin
      reset = 1'b1; we = 1'b0; re = 1'b0; addr = 7'h00; wdat = '0;
      in_valid = 1'b0; in_dat = '0;
      repeat (3) @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // reset defaults and window edges
      rd_busy(A_STATUS, "rst_status", 32'h0, 1'b0);
      rd(A_LENGTH, "rst_length", 32'd1);
      rd(A_TRIG,   "rst_trig",   32'd0);
      rd(A_CTRL,   "rst_ctrl",   32'd0);
      rd_miss(BASE + 7'd5, "miss_above");
      rd_miss(BASE - 7'd1, "miss_below");

      // basic capture: LENGTH=4, no trigger, no decimation
      bus_write(A_LENGTH, 32'd4);
      bus_write(A_CTRL, 32'h1);
      rd_busy(A_STATUS, "t1_armed", 32'h0000_0001, 1'b1);
      foreach (t1_in[i]) send_valid(t1_in[i]);
      rd_busy(A_STATUS, "t1_done", 32'h0008_0004, 1'b0);
      for (int unsigned i = 0; i < 8; i++) begin
         rd(A_DATA, $sformatf("t1_data%0d", i), t1_data[i]);
         if (i == 3) rd(A_STATUS, "t1_status_mid", 32'h0008_0004);
      end

      // threshold trigger on |ch0| > 100
      bus_write(A_TRIG, 32'd100);
      bus_write(A_LENGTH, 32'd2);
      bus_write(A_CTRL, 32'h5);
      send_valid(t2_in[0]);
      send_valid(t2_in[1]);
      rd(A_STATUS, "t2_still_armed", 32'h0000_0001);
      send_valid(t2_in[2]);
      send_valid(t2_in[3]);
      rd(A_STATUS, "t2_done", 32'h0004_0004);
      foreach (t2_data[i]) rd(A_DATA, $sformatf("t2_data%0d", i), t2_data[i]);

      // most negative ch0 saturates to 32767
      bus_write(A_TRIG, 32'h7FFF);
      bus_write(A_LENGTH, 32'd1);
      bus_write(A_CTRL, 32'h5);
      send_valid(32'h0000_8000);
      rd(A_STATUS, "sat_no_trig", 32'h0000_0001);
      bus_write(A_TRIG, 32'h7FFE);
      send_valid(32'h0000_8000);
      rd(A_STATUS, "sat_trig", 32'h0002_0004);
      rd(A_DATA, "sat_data", 32'hFFFF_8000);

      // decimation by 3 (accept one, discard two)
      bus_write(A_LENGTH, 32'd3);
      bus_write(A_CTRL, 32'h0201);
      rd(A_CTRL, "t3_ctrl", 32'h0000_0200);
      for (int unsigned n = 0; n < 9; n++)
         send_valid({16'(n + 100), 16'(n)});
      rd(A_STATUS, "t3_done", 32'h0006_0004);
      foreach (t3_data[i]) rd(A_DATA, $sformatf("t3_data%0d", i), t3_data[i]);

      // overrun on back-to-back sets, cleared by re-arm
      bus_write(A_LENGTH, 32'd4);
      bus_write(A_CTRL, 32'h1);
      send_pair(32'h0002_0001, 32'h0004_0003);
      rd(A_STATUS, "ovr_set", 32'h0002_000A);
      bus_write(A_CTRL, 32'h1);
      rd(A_STATUS, "ovr_cleared", 32'h0000_0001);

      // abort mid-capture freezes words; arm+abort together stays idle
      send_valid(32'h0008_0007);
      rd_busy(A_STATUS, "abort_pre", 32'h0002_0002, 1'b1);
      bus_write(A_CTRL, 32'h2);
      rd_busy(A_STATUS, "abort_idle", 32'h0002_0000, 1'b0);
      send_valid(32'h0009_0009);
      rd(A_STATUS, "abort_frozen", 32'h0002_0000);
      bus_write(A_CTRL, 32'h3);
      rd_busy(A_STATUS, "arm_abort", 32'h0002_0000, 1'b0);
      rd(A_DATA, "abort_data", 32'h0000_0007);

      // reset mid-capture restores defaults
      bus_write(A_TRIG, 32'd55);
      bus_write(A_CTRL, 32'h0301);
      send_valid(32'h0001_0001);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      rd_busy(A_STATUS, "rst2_status", 32'h0, 1'b0);
      rd(A_LENGTH, "rst2_length", 32'd1);
      rd(A_TRIG,   "rst2_trig",   32'd0);
      rd(A_CTRL,   "rst2_ctrl",   32'd0);

      // LENGTH clamping and read-only writes
      bus_write(A_LENGTH, 32'd0);
      rd(A_LENGTH, "len_zero", 32'd1);
      bus_write(A_LENGTH, 32'd512);
      rd(A_LENGTH, "len_full", 32'd256);
      bus_write(A_LENGTH, 32'd300);
      rd(A_LENGTH, "len_over", 32'd256);
      bus_write(A_LENGTH, 32'd5);
      rd(A_LENGTH, "len_five", 32'd5);
      bus_write(A_STATUS, 32'hFFFF_FFFF);
      rd(A_STATUS, "status_ro", 32'h0);

      for (int unsigned i = 0; i < 50 && exp_q.size() != 0; i++)
         @(posedge clk);
      if (exp_q.size() != 0) begin
         total += exp_q.size();
         bad   += exp_q.size();
         $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time=%0t exp=finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
